// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 pixel serializer: FSM states, default
// 50 MHz timing and counter width helpers.
package ws2812_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW,
    ST_LATCH
  } state_e;

  localparam int unsigned DEF_BITS     = 24;
  localparam int unsigned DEF_T0H_CYC  = 20;
  localparam int unsigned DEF_T1H_CYC  = 40;
  localparam int unsigned DEF_TBIT_CYC = 63;
  localparam int unsigned DEF_TRST_CYC = 2500;

  function automatic int unsigned cnt_width(input int unsigned tbit, input int unsigned trst);
    int unsigned m;
    m = (tbit > trst) ? tbit : trst;
    return $clog2(m + 1);
  endfunction

  // A single-bit pixel still needs a one-bit index register.
  function automatic int unsigned idx_width(input int unsigned bits);
    return (bits > 1) ? $clog2(bits) : 1;
  endfunction

endpackage

// File: rtl/ws2812_pixel_serializer_if.sv
// Pixel stream handshake between the frame sequencer (master) and the
// serializer (slave).
interface ws2812_pixel_serializer_if #(
  parameter int unsigned BITS = 24
);
  logic [BITS-1:0] pix_data;
  logic            pix_valid;
  logic            pix_last;
  logic            pix_ready;

  modport master (output pix_data, output pix_valid, output pix_last, input pix_ready);
  modport slave  (input pix_data, input pix_valid, input pix_last, output pix_ready);
endinterface

// File: rtl/ws2812_cycle_timer.sv
// Loadable down-counter shared by the HIGH, LOW and LATCH phases; done_o is
// high while the count sits at zero.
module ws2812_cycle_timer #(
  parameter int unsigned W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);
endmodule

// File: rtl/ws2812_pixel_serializer.sv
// WS2812-class NRZ serializer: accepts pixels over valid/ready, shifts them
// out MSB-first with gap-free bits and a latch gap after the last pixel.
module ws2812_pixel_serializer
  import ws2812_pkg::*;
#(
  parameter int unsigned BITS     = DEF_BITS,
  parameter int unsigned T0H_CYC  = DEF_T0H_CYC,
  parameter int unsigned T1H_CYC  = DEF_T1H_CYC,
  parameter int unsigned TBIT_CYC = DEF_TBIT_CYC,
  parameter int unsigned TRST_CYC = DEF_TRST_CYC
) (
  input  logic                         clk,
  input  logic                         rst,
  ws2812_pixel_serializer_if.slave     pix,
  output logic                         led_out,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         underrun
);
  localparam int unsigned CW = cnt_width(TBIT_CYC, TRST_CYC);
  localparam int unsigned IW = idx_width(BITS);

  // Timer reloads are phase length minus one: the load cycle counts.
  localparam logic [CW-1:0] T0H_LD  = CW'(T0H_CYC - 1);
  localparam logic [CW-1:0] T1H_LD  = CW'(T1H_CYC - 1);
  localparam logic [CW-1:0] T0L_LD  = CW'(TBIT_CYC - T0H_CYC - 1);
  localparam logic [CW-1:0] T1L_LD  = CW'(TBIT_CYC - T1H_CYC - 1);
  localparam logic [CW-1:0] TRST_LD = CW'(TRST_CYC - 1);
  localparam logic [IW-1:0] IDX_TOP = IW'(BITS - 1);

  if (!(T0H_CYC > 0 && T0H_CYC < T1H_CYC && T1H_CYC < TBIT_CYC &&
        TRST_CYC >= TBIT_CYC && BITS >= 1)) begin : g_param_check
    $error("ws2812_pixel_serializer: need 0<T0H<T1H<TBIT, TRST>=TBIT, BITS>=1");
  end

  state_e          state_q;
  logic [BITS-1:0] shift_q;
  logic [BITS-1:0] shift_nx;
  logic            last_q;
  logic [IW-1:0]   idx_q;
  logic            led_q, busy_q, done_q, under_q;

  logic            tmr_load;
  logic [CW-1:0]   tmr_val;
  logic            tmr_done;
  logic            boundary;
  logic            accept;

  assign shift_nx = shift_q << 1;
  // Final LOW cycle of bit 0 of a non-last pixel: the next pixel may be taken here.
  assign boundary      = (state_q == ST_LOW) && tmr_done && (idx_q == '0) && !last_q;
  assign pix.pix_ready = !rst && ((state_q == ST_IDLE) || boundary);
  assign accept        = pix.pix_valid && pix.pix_ready;

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          tmr_load = 1'b1;
          tmr_val  = pix.pix_data[BITS-1] ? T1H_LD : T0H_LD;
        end
      end
      ST_HIGH: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = shift_q[BITS-1] ? T1L_LD : T0L_LD;
        end
      end
      ST_LOW: begin
        if (tmr_done) begin
          if (idx_q != '0) begin
            tmr_load = 1'b1;
            tmr_val  = shift_nx[BITS-1] ? T1H_LD : T0H_LD;
          end else if (last_q) begin
            tmr_load = 1'b1;
            tmr_val  = TRST_LD;
          end else if (accept) begin
            tmr_load = 1'b1;
            tmr_val  = pix.pix_data[BITS-1] ? T1H_LD : T0H_LD;
          end
        end
      end
      default: ;
    endcase
  end

  ws2812_cycle_timer #(.W(CW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      under_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      under_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            shift_q <= pix.pix_data;
            last_q  <= pix.pix_last;
            idx_q   <= IDX_TOP;
            led_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (tmr_done) begin
            led_q   <= 1'b0;
            state_q <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (tmr_done) begin
            if (idx_q != '0) begin
              idx_q   <= idx_q - 1'b1;
              shift_q <= shift_nx;
              led_q   <= 1'b1;
              state_q <= ST_HIGH;
            end else if (last_q) begin
              state_q <= ST_LATCH;
            end else if (accept) begin
              shift_q <= pix.pix_data;
              last_q  <= pix.pix_last;
              idx_q   <= IDX_TOP;
              led_q   <= 1'b1;
              state_q <= ST_HIGH;
            end else begin
              under_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
        end
        ST_LATCH: begin
          if (tmr_done) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign led_out    = led_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign underrun   = under_q;
endmodule

// File: tb/tb_ws2812_pixel_serializer.sv
// Bench for ws2812_pixel_serializer: default-timing instance (a) and a short
// 32-bit instance (b), compared cycle by cycle against a waveform model.
module tb_ws2812_pixel_serializer;
  localparam int NC = 8192;

  logic clk = 1'b0;
  logic rst;
  logic led_a, busy_a, fd_a, ur_a;
  logic led_b, busy_b, fd_b, ur_b;

  ws2812_pixel_serializer_if #(.BITS(24)) pa ();
  ws2812_pixel_serializer_if #(.BITS(32)) pb ();

  ws2812_pixel_serializer #(.BITS(24), .T0H_CYC(20), .T1H_CYC(40), .TBIT_CYC(63), .TRST_CYC(2500)) dut_a (
    .clk(clk), .rst(rst), .pix(pa), .led_out(led_a), .busy(busy_a), .frame_done(fd_a), .underrun(ur_a));

  ws2812_pixel_serializer #(.BITS(32), .T0H_CYC(2), .T1H_CYC(4), .TBIT_CYC(6), .TRST_CYC(10)) dut_b (
    .clk(clk), .rst(rst), .pix(pb), .led_out(led_b), .busy(busy_b), .frame_done(fd_b), .underrun(ur_b));

  always #5 clk = ~clk;

  int checks, failures;
  logic [31:0] src_data[4];
  bit          src_last[4];
  int          src_delay[4];
  int          exp_acc[4];
  int          acc_cy[4];
  bit          exp_led[NC], exp_rdy[NC], exp_fd[NC], exp_ur[NC], exp_busy[NC];
  logic        obs_led[NC], obs_rdy[NC], obs_fd[NC], obs_ur[NC], obs_busy[NC];
  int          m_led, m_ctl, m_acc, f_led, f_ctl;

  // Expected waveform from the protocol rules: each accepted pixel occupies
  // bits*tbit cycles starting at its acceptance cycle.
  task automatic build_model(input int n, input int bits, input int t0h, input int t1h,
                             input int tbit, input int trst);
    int a, e, h, c;
    for (int i = 0; i < NC; i++) begin
      exp_led[i] = 0; exp_rdy[i] = 1; exp_fd[i] = 0; exp_ur[i] = 0; exp_busy[i] = 0;
    end
    for (int i = 0; i < n; i++) begin
      a = exp_acc[i];
      for (int b = 0; b < bits; b++) begin
        h = src_data[i][bits-1-b] ? t1h : t0h;
        for (int k = 0; k < tbit; k++) begin
          c = a + b * tbit + k;
          exp_led[c] = (k < h); exp_rdy[c] = 0; exp_busy[c] = 1;
        end
      end
      e = a + bits * tbit;
      if (!src_last[i]) begin
        exp_rdy[e-1] = 1;
        if (i + 1 >= n || exp_acc[i+1] != e) exp_ur[e] = 1;
      end else begin
        for (int k = 0; k < trst; k++) begin exp_rdy[e+k] = 0; exp_busy[e+k] = 1; end
        exp_fd[e+trst] = 1;
      end
    end
  endtask

  // Drives the source (valid held until accepted) and records outputs each
  // negedge; tallies differences from the model for the calling test.
  task automatic run(input bit sel, input int n, input int ncyc);
    int idx, wait_cnt;
    bit pend, rdy;
    idx = 0; wait_cnt = src_delay[0]; pend = 0;
    m_led = 0; m_ctl = 0; m_acc = 0; f_led = -1; f_ctl = -1;
    for (int i = 0; i < 4; i++) acc_cy[i] = -1;
    for (int cy = 0; cy < ncyc; cy++) begin
      obs_led[cy]  = sel ? led_b : led_a;
      obs_rdy[cy]  = sel ? pb.pix_ready : pa.pix_ready;
      obs_fd[cy]   = sel ? fd_b : fd_a;
      obs_ur[cy]   = sel ? ur_b : ur_a;
      obs_busy[cy] = sel ? busy_b : busy_a;
      if (pend) begin
        acc_cy[idx] = cy; idx++;
        if (idx < n) wait_cnt = src_delay[idx];
      end
      if (idx < n && wait_cnt == 0) begin
        if (sel) begin pb.pix_valid = 1; pb.pix_data = src_data[idx]; pb.pix_last = src_last[idx]; end
        else begin pa.pix_valid = 1; pa.pix_data = src_data[idx][23:0]; pa.pix_last = src_last[idx]; end
      end else begin
        pa.pix_valid = 0; pb.pix_valid = 0;
        if (idx < n) wait_cnt--;
      end
      rdy  = sel ? pb.pix_ready : pa.pix_ready;
      pend = (sel ? pb.pix_valid : pa.pix_valid) && rdy;
      if (obs_led[cy] !== exp_led[cy]) begin if (m_led == 0) f_led = cy; m_led++; end
      if ({obs_rdy[cy], obs_fd[cy], obs_ur[cy], obs_busy[cy]} !==
          {exp_rdy[cy], exp_fd[cy], exp_ur[cy], exp_busy[cy]}) begin
        if (m_ctl == 0) f_ctl = cy;
        m_ctl++;
      end
      @(negedge clk);
    end
    pa.pix_valid = 0; pb.pix_valid = 0;
    for (int i = 0; i < n; i++) if (acc_cy[i] != exp_acc[i]) m_acc++;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    checks++; if (led_a !== 1'b0) begin failures++; $display("FAIL reset_led got=%b want=0", led_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy_a); end
    checks++; if ({fd_a, ur_a} !== 2'b00) begin failures++; $display("FAIL reset_pulses got=%b want=00", {fd_a, ur_a}); end
    checks++; if ({led_b, busy_b, fd_b, ur_b} !== 4'b0) begin failures++; $display("FAIL reset_b got=%b want=0000", {led_b, busy_b, fd_b, ur_b}); end
    rst = 0;
    @(negedge clk);
    checks++; if (pa.pix_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", pa.pix_ready); end
  endtask

  task automatic test_single_pixel();
    int bad_w, w;
    src_data[0] = 32'hFF0000; src_last[0] = 1; src_delay[0] = 0; exp_acc[0] = 1;
    build_model(1, 24, 20, 40, 63, 2500);
    run(0, 1, 4020);
    checks++; if (m_led !== 0) begin failures++; $display("FAIL single_wave mismatches=%0d first=%0d want=0", m_led, f_led); end
    checks++; if (m_ctl !== 0) begin failures++; $display("FAIL single_ctl mismatches=%0d first=%0d want=0", m_ctl, f_ctl); end
    checks++; if (m_acc !== 0) begin failures++; $display("FAIL single_accept got=%0d want=%0d", acc_cy[0], exp_acc[0]); end
    bad_w = 0;
    for (int b = 0; b < 24; b++) begin
      w = 0;
      for (int k = 0; k < 63; k++) w += (obs_led[1 + b * 63 + k] === 1'b1) ? 1 : 0;
      if (w != ((b < 8) ? 40 : 20)) bad_w++;
    end
    checks++; if (bad_w !== 0) begin failures++; $display("FAIL single_widths bad_bits=%0d want=0", bad_w); end
    checks++; if (obs_fd[4013] !== 1'b1) begin failures++; $display("FAIL single_done_at_4013 got=%b want=1", obs_fd[4013]); end
  endtask

  task automatic test_back_to_back();
    int nr;
    for (int i = 0; i < 3; i++) begin
      src_data[i] = $urandom & 32'hFFFFFF; src_last[i] = (i == 2); src_delay[i] = 0;
      exp_acc[i] = 1 + i * 1512;
    end
    build_model(3, 24, 20, 40, 63, 2500);
    run(0, 3, 7045);
    checks++; if (m_led !== 0) begin failures++; $display("FAIL b2b_wave mismatches=%0d first=%0d want=0", m_led, f_led); end
    checks++; if (m_ctl !== 0) begin failures++; $display("FAIL b2b_ctl mismatches=%0d first=%0d want=0", m_ctl, f_ctl); end
    checks++; if (m_acc !== 0) begin failures++; $display("FAIL b2b_accept got=%0d,%0d,%0d want=1,1513,3025", acc_cy[0], acc_cy[1], acc_cy[2]); end
    nr = 0;
    for (int c = 1; c < 1 + 72 * 63; c++) nr += (obs_rdy[c] === 1'b1) ? 1 : 0;
    checks++;
    if (nr != 2 || obs_rdy[1512] !== 1'b1 || obs_rdy[3024] !== 1'b1) begin
      failures++; $display("FAIL b2b_ready_pulses got=%0d want=2 at 1512,3024", nr);
    end
  endtask

  task automatic test_underrun();
    src_data[0] = $urandom & 32'hFFFFFF; src_last[0] = 0; src_delay[0] = 0;
    src_data[1] = $urandom & 32'hFFFFFF; src_last[1] = 1; src_delay[1] = 1511 + 10;
    exp_acc[0] = 1; exp_acc[1] = 1 + 1521 + 1;
    build_model(2, 24, 20, 40, 63, 2500);
    run(0, 2, 5545);
    checks++; if (m_led !== 0) begin failures++; $display("FAIL underrun_wave mismatches=%0d first=%0d want=0", m_led, f_led); end
    checks++; if (m_ctl !== 0) begin failures++; $display("FAIL underrun_ctl mismatches=%0d first=%0d want=0", m_ctl, f_ctl); end
    checks++; if (m_acc !== 0) begin failures++; $display("FAIL underrun_accept got=%0d want=%0d", acc_cy[1], exp_acc[1]); end
    checks++; if (obs_ur[1513] !== 1'b1) begin failures++; $display("FAIL underrun_pulse got=%b want=1", obs_ur[1513]); end
  endtask

  task automatic test_reset_mid_frame();
    int nfd;
    pa.pix_valid = 1; pa.pix_data = ($urandom & 24'hFFFFFF) | 24'h040000; pa.pix_last = 1;
    @(negedge clk);
    pa.pix_valid = 0;
    repeat (5 * 63 + 2) @(negedge clk);
    checks++; if (led_a !== 1'b1) begin failures++; $display("FAIL midrst_high_before got=%b want=1", led_a); end
    #2 rst = 1;
    #1;
    checks++; if ({led_a, busy_a} !== 2'b00) begin failures++; $display("FAIL midrst_async got=%b want=00", {led_a, busy_a}); end
    repeat (3) @(negedge clk);
    rst = 0;
    nfd = 0;
    for (int c = 0; c < 200; c++) begin @(negedge clk); nfd += (fd_a === 1'b1 || led_a !== 1'b0) ? 1 : 0; end
    checks++; if (nfd !== 0) begin failures++; $display("FAIL midrst_quiet got=%0d want=0", nfd); end
    src_data[0] = $urandom & 32'hFFFFFF; src_last[0] = 1; src_delay[0] = 0; exp_acc[0] = 1;
    build_model(1, 24, 20, 40, 63, 2500);
    run(0, 1, 4020);
    checks++; if (m_led !== 0) begin failures++; $display("FAIL midrst_next_wave mismatches=%0d first=%0d want=0", m_led, f_led); end
    checks++; if (m_ctl !== 0) begin failures++; $display("FAIL midrst_next_ctl mismatches=%0d first=%0d want=0", m_ctl, f_ctl); end
  endtask

  task automatic test_wide_params();
    int widths[8] = '{4, 2, 4, 2, 2, 4, 2, 4};
    int w, bad_w;
    src_data[0] = 32'hA5A5A5A5; src_last[0] = 1; src_delay[0] = 0; exp_acc[0] = 1;
    src_data[1] = $urandom;     src_last[1] = 1; src_delay[1] = 250; exp_acc[1] = 252;
    build_model(2, 32, 2, 4, 6, 10);
    run(1, 2, 470);
    checks++; if (m_led !== 0) begin failures++; $display("FAIL wide_wave mismatches=%0d first=%0d want=0", m_led, f_led); end
    checks++; if (m_ctl !== 0) begin failures++; $display("FAIL wide_ctl mismatches=%0d first=%0d want=0", m_ctl, f_ctl); end
    checks++; if (m_acc !== 0) begin failures++; $display("FAIL wide_accept got=%0d,%0d want=1,252", acc_cy[0], acc_cy[1]); end
    checks++; if (obs_fd[203] !== 1'b1) begin failures++; $display("FAIL wide_done_at_203 got=%b want=1", obs_fd[203]); end
    bad_w = 0;
    for (int b = 0; b < 32; b++) begin
      w = 0;
      for (int k = 0; k < 6; k++) w += (obs_led[1 + b * 6 + k] === 1'b1) ? 1 : 0;
      if (w != widths[b % 8]) bad_w++;
    end
    checks++; if (bad_w !== 0) begin failures++; $display("FAIL wide_widths bad_bits=%0d want=0", bad_w); end
  endtask

  task automatic test_valid_during_latch();
    src_data[0] = $urandom & 32'hFFFFFF; src_last[0] = 1; src_delay[0] = 0;
    src_data[1] = $urandom & 32'hFFFFFF; src_last[1] = 1; src_delay[1] = 1600;
    exp_acc[0] = 1; exp_acc[1] = 1 + 1512 + 2500 + 1;
    build_model(2, 24, 20, 40, 63, 2500);
    run(0, 2, 8035);
    checks++; if (m_led !== 0) begin failures++; $display("FAIL latch_wave mismatches=%0d first=%0d want=0", m_led, f_led); end
    checks++; if (m_ctl !== 0) begin failures++; $display("FAIL latch_ctl mismatches=%0d first=%0d want=0", m_ctl, f_ctl); end
    checks++; if (m_acc !== 0) begin failures++; $display("FAIL latch_accept got=%0d want=%0d", acc_cy[1], exp_acc[1]); end
  endtask

  initial begin
    checks = 0; failures = 0; rst = 1;
    pa.pix_valid = 0; pa.pix_data = '0; pa.pix_last = 0;
    pb.pix_valid = 0; pb.pix_data = '0; pb.pix_last = 0;
    test_reset();
    test_single_pixel();
    test_back_to_back();
    test_underrun();
    test_reset_mid_frame();
    test_wide_params();
    test_valid_during_latch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
